riscv_mult_seq: RTL and testbench
=================================

RISCV_MULT_SEQ -- requirements
Module: riscv_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter CHUNK, default 16: partial-product slice width; WIDTH mod CHUNK == 0, with N = WIDTH/CHUNK.
REQ-003 SHALL have port clk  in  1  -- sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  -- reset, synchronous and active-low.
REQ-005 SHALL have ports valid_i  in  1 (request present) and ready_o  out  1 (request can be accepted).
REQ-006 SHALL have port operator_i  in  2  -- MUL_LO, MUL_MAC or MUL_HI.
REQ-007 SHALL have port signed_i  in  2  -- bit0 treats op_a_i as signed, bit1 treats op_b_i as signed.
REQ-008 SHALL have ports op_a_i, op_b_i, op_c_i  in  WIDTH  -- multiplicand, multiplier, accumulate addend.
REQ-009 SHALL have port flush_i  in  1  -- abort the current operation.
REQ-010 SHALL have ports result_o  out  WIDTH (result), valid_o  out  1 (result valid) and multicycle_o  out  1 (high while in CALC).
REQ-011 SHALL have port ex_ready_i  in  1  -- consumer takes the result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 SHALL drive ready_o high only in IDLE; acceptance = valid_i & ready_o & ~flush_i.
REQ-014 SHALL, on acceptance, register operands, operator and signedness, clear step counter k, load the 2*WIDTH accumulator (sign-extended op_c_i for MUL_MAC, else 0), and enter CALC.
REQ-015 SHALL, in CALC, add one partial product per cycle: i = k mod N, j = k div N.
REQ-016 SHALL form each partial product as a (CHUNK+1)x(CHUNK+1) signed product of a-slice i and b-slice j.
REQ-017 SHALL set the extension bit of a slice to slice MSB & signed bit only for the top slice (i or j == N-1), else 0.
REQ-018 SHALL shift each partial product left by (i+j)*CHUNK and sign-extend it to 2*WIDTH before accumulating.
REQ-019 SHALL go from CALC to DONE after step k = N*N-1, so valid_o rises N*N edges after the acceptance edge.
REQ-020 SHALL, in DONE, hold valid_o high and result_o stable; result_o = acc[WIDTH-1:0] for MUL_LO/MUL_MAC, acc[2*WIDTH-1:WIDTH] for MUL_HI.
REQ-021 SHALL go from DONE to IDLE at the edge where ex_ready_i is high; there is no back-to-back acceptance from DONE.
REQ-022 SHALL, when flush_i is high in CALC or DONE, go to IDLE at the next edge, with valid_o low from then and the result discarded.
REQ-023 SHALL give flush_i priority over ex_ready_i and over acceptance.
REQ-024 SHALL drive result_o as 0 whenever valid_o is low.

Reset
REQ-025 SHALL, on rst_n low at a clock edge (including mid-CALC), enter IDLE and clear the accumulator, k and all registered operands.
REQ-026 SHALL then drive valid_o = 0, multicycle_o = 0, result_o = 0 and ready_o = 1 (IDLE).

Configuration
REQ-027 SHALL, with macro RISCV_MULT_EARLY_OUT_EN defined, go from CALC directly to DONE at any step with i == 0 where registered b[WIDTH-1:j*CHUNK] == 0, skipping the remaining steps without changing the result.
REQ-028 SHALL, without RISCV_MULT_EARLY_OUT_EN, take exactly N*N CALC cycles for every operation.

Structure
REQ-029 SHALL define the operator encodings MUL_LO, MUL_MAC and MUL_HI, and the FSM state typedef, in the shared riscv_defines package.
REQ-030 SHALL place the slice extension and shift of one partial product in a combinational sub-module riscv_mult_pp, instantiated once.
REQ-031 SHALL check WIDTH mod CHUNK == 0 with an elaboration-time check.

Verification (WIDTH=32, CHUNK=16, macro off unless stated)
REQ-032 SHALL cover MUL_HI, signed_i=00, a=b=0xFFFFFFFF -> result 0xFFFFFFFE, valid_o rising 4 edges after acceptance.
REQ-033 SHALL cover MUL_HI, signed_i=11, a=b=0x80000000 -> 0x40000000; signed_i=01, a=b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 SHALL cover MUL_MAC, signed_i=11, c=10, a=3, b=0xFFFFFFFE -> 0x00000004.
REQ-035 SHALL cover flush_i pulsed after 2 CALC cycles -> IDLE next edge, no valid_o pulse; next MUL_LO 7*6 -> 42.
REQ-036 SHALL cover ex_ready_i held low 3 cycles in DONE -> result_o and valid_o held; IDLE at the edge ex_ready_i is high.
REQ-037 SHALL cover the macro defined: b=0 -> valid after 1 CALC cycle, result 0; b=0x0000FFFF, a=2 MUL_LO -> 0x0001FFFE after 3 CALC cycles.

Source files
------------

// File: rtl/riscv_mult_seq_pkg.sv
// Shared definitions for the sequential multiplier: operator encodings and FSM states.
package riscv_defines;

  localparam logic [1:0] MUL_LO  = 2'd0;
  localparam logic [1:0] MUL_MAC = 2'd1;
  localparam logic [1:0] MUL_HI  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/riscv_mult_seq_pp.sv
// One partial product: (CHUNK+1)x(CHUNK+1) signed slice multiply, sign-extended to
// 2*WIDTH and shifted into place.
module riscv_mult_pp #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16,
  parameter int SW    = 3
) (
  input  logic [CHUNK-1:0]   a_slice,
  input  logic [CHUNK-1:0]   b_slice,
  input  logic               a_top,
  input  logic               b_top,
  input  logic [1:0]         sign_mode,
  input  logic [SW-1:0]      shift_idx,
  output logic [2*WIDTH-1:0] pp
);

  localparam int PW = 2*CHUNK + 2;

  logic                 a_ext_s;
  logic                 b_ext_s;
  logic signed [CHUNK:0] a_op_s;
  logic signed [CHUNK:0] b_op_s;
  logic signed [PW-1:0]  prod_s;
  logic [2*WIDTH-1:0]    ext_s;

  // Only the most significant slice carries the operand sign.
  always_comb begin
    a_ext_s = a_slice[CHUNK-1] & sign_mode[0] & a_top;
    b_ext_s = b_slice[CHUNK-1] & sign_mode[1] & b_top;
    a_op_s  = {a_ext_s, a_slice};
    b_op_s  = {b_ext_s, b_slice};
    prod_s  = a_op_s * b_op_s;
  end

  generate
    if (PW < 2*WIDTH) begin : g_sext
      assign ext_s = {{(2*WIDTH-PW){prod_s[PW-1]}}, prod_s};
    end else begin : g_trunc
      assign ext_s = prod_s[2*WIDTH-1:0];
    end
  endgenerate

  // Align the product to its (i+j)*CHUNK weight.
  always_comb begin
    pp = ext_s << (int'(shift_idx) * CHUNK);
  end

endmodule

// File: rtl/riscv_mult_seq.sv
// Sequential chunked multiplier (MUL_LO / MUL_MAC / MUL_HI), one partial product per cycle.
// Optional macro RISCV_MULT_EARLY_OUT_EN ends CALC early once the remaining multiplier bits are zero.
module riscv_mult_seq
  import riscv_defines::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       operator_i,
  input  logic [1:0]       signed_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [WIDTH-1:0] op_c_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  output logic             multicycle_o,
  input  logic             ex_ready_i
);

  localparam int N  = WIDTH / CHUNK;
  localparam int NN = N * N;
  localparam int KW = $clog2(NN + 1);
  localparam int SW = $clog2(2 * N) + 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_width_check
      $error("riscv_mult_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  mult_state_e        state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [1:0]         op_r;
  logic [1:0]         sign_r;
  logic [KW-1:0]      k_r;
  logic [2*WIDTH-1:0] acc_r;

  int                 i_s;
  int                 j_s;
  logic [CHUNK-1:0]   a_slice_s;
  logic [CHUNK-1:0]   b_slice_s;
  logic               a_top_s;
  logic               b_top_s;
  logic [SW-1:0]      shift_idx_s;
  logic [2*WIDTH-1:0] pp_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0]   result_sel_s;
  logic               last_s;
  logic               early_s;

  // Step decode, slice selection, next accumulator and result select.
  always_comb begin
    i_s          = int'(k_r) % N;
    j_s          = int'(k_r) / N;
    a_slice_s    = a_r[i_s*CHUNK +: CHUNK];
    b_slice_s    = b_r[j_s*CHUNK +: CHUNK];
    a_top_s      = (i_s == N - 1);
    b_top_s      = (j_s == N - 1);
    shift_idx_s  = SW'(i_s + j_s);
    acc_next_s   = acc_r + pp_s;
    last_s       = (int'(k_r) == NN - 1);
    if (op_r == MUL_HI) begin
      result_sel_s = acc_next_s[2*WIDTH-1:WIDTH];
    end else begin
      result_sel_s = acc_next_s[WIDTH-1:0];
    end
`ifdef RISCV_MULT_EARLY_OUT_EN
    early_s = (i_s == 0) && ((b_r >> (j_s * CHUNK)) == {WIDTH{1'b0}});
`else
    early_s = 1'b0;
`endif
  end

  riscv_mult_pp #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK),
    .SW    (SW)
  ) u_pp (
    .a_slice   (a_slice_s),
    .b_slice   (b_slice_s),
    .a_top     (a_top_s),
    .b_top     (b_top_s),
    .sign_mode (sign_r),
    .shift_idx (shift_idx_s),
    .pp        (pp_s)
  );

  // Control FSM with registered handshake and result outputs; flush wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      op_r         <= 2'b00;
      sign_r       <= 2'b00;
      k_r          <= {KW{1'b0}};
      acc_r        <= {(2*WIDTH){1'b0}};
      ready_o      <= 1'b1;
      valid_o      <= 1'b0;
      multicycle_o <= 1'b0;
      result_o     <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (valid_i && ready_o && !flush_i) begin
            state_r      <= CALC;
            a_r          <= op_a_i;
            b_r          <= op_b_i;
            op_r         <= operator_i;
            sign_r       <= signed_i;
            k_r          <= {KW{1'b0}};
            acc_r        <= (operator_i == MUL_MAC) ?
                            {{WIDTH{op_c_i[WIDTH-1]}}, op_c_i} : {(2*WIDTH){1'b0}};
            ready_o      <= 1'b0;
            multicycle_o <= 1'b1;
          end else begin
            ready_o      <= 1'b1;
          end
        end
        CALC: begin
          if (flush_i) begin
            state_r      <= IDLE;
            ready_o      <= 1'b1;
            multicycle_o <= 1'b0;
            valid_o      <= 1'b0;
            result_o     <= {WIDTH{1'b0}};
          end else begin
            acc_r <= acc_next_s;
            k_r   <= k_r + KW'(1'b1);
            if (last_s || early_s) begin
              state_r      <= DONE;
              multicycle_o <= 1'b0;
              valid_o      <= 1'b1;
              result_o     <= result_sel_s;
            end else begin
              state_r      <= CALC;
            end
          end
        end
        DONE: begin
          if (flush_i || ex_ready_i) begin
            state_r  <= IDLE;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            result_o <= {WIDTH{1'b0}};
          end else begin
            state_r  <= DONE;
          end
        end
        default: begin
          state_r      <= IDLE;
          ready_o      <= 1'b1;
          valid_o      <= 1'b0;
          multicycle_o <= 1'b0;
          result_o     <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mult_seq.sv
// Self-checking bench for riscv_mult_seq: vector table plus handshake/flush/reset sequences.
module tb_riscv_mult_seq;
  import riscv_defines::*;

  localparam int W = 32;
`ifdef RISCV_MULT_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_i;
  logic         ready_o;
  logic [1:0]   operator_i;
  logic [1:0]   signed_i;
  logic [W-1:0] op_a_i;
  logic [W-1:0] op_b_i;
  logic [W-1:0] op_c_i;
  logic         flush_i;
  logic [W-1:0] result_o;
  logic         valid_o;
  logic         multicycle_o;
  logic         ex_ready_i;

  always #5 clk = ~clk;

  riscv_mult_seq #(.WIDTH(W), .CHUNK(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .operator_i   (operator_i),
    .signed_i     (signed_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .op_c_i       (op_c_i),
    .flush_i      (flush_i),
    .result_o     (result_o),
    .valid_o      (valid_o),
    .multicycle_o (multicycle_o),
    .ex_ready_i   (ex_ready_i)
  );

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] sb_q[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected CALC cycles: N*N = 4, or fewer when early-out sees the upper b bits all zero.
  function automatic int exp_lat(input logic [31:0] b);
    int lat = 4;
    for (int k = 3; k >= 0; k--) begin
      if (EARLY && (k % 2) == 0 && (b >> ((k / 2) * 16)) == 32'd0) lat = k + 1;
    end
    return lat;
  endfunction

  task automatic drive(input vec_t v);
    operator_i = v.op;
    signed_i   = v.sgn;
    op_a_i     = v.a;
    op_b_i     = v.b;
    op_c_i     = v.c;
    valid_i    = 1'b1;
  endtask

  task automatic do_op(input vec_t v, input int hold, input string name);
    int          cnt;
    logic [31:0] e;
    cnt = 0;
    while (!ready_o && cnt < 20) begin @(posedge clk); #1; cnt++; end
    chk({name, "_ready"}, 64'(ready_o), 64'd1);
    drive(v);
    @(posedge clk); #1;
    valid_i = 1'b0;
    sb_q.push_back(v.exp);
    chk({name, "_calc"}, {62'd0, multicycle_o, ready_o}, 64'd2);
    cnt = 0;
    while (!valid_o && cnt < 50) begin @(posedge clk); #1; cnt++; end
    chk({name, "_lat"}, 64'(cnt), 64'(exp_lat(v.b)));
    e = sb_q.pop_front();
    chk({name, "_res"}, {31'd0, valid_o, result_o}, {31'd0, 1'b1, e});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({name, "_hold"}, {31'd0, valid_o, result_o}, {31'd0, 1'b1, e});
    end
    ex_ready_i = 1'b1;
    @(posedge clk); #1;
    ex_ready_i = 1'b0;
    chk({name, "_idle"}, {30'd0, valid_o, ready_o, result_o}, {30'd0, 1'b0, 1'b1, 32'd0});
  endtask

  initial begin
    vec_t v;
    int   cnt;
    int   seen;
    vecs[0]  = '{MUL_HI,  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,       32'hFFFFFFFE};
    vecs[1]  = '{MUL_HI,  2'b11, 32'h80000000, 32'h80000000, 32'd0,       32'h40000000};
    vecs[2]  = '{MUL_HI,  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,       32'hFFFFFFFF};
    vecs[3]  = '{MUL_MAC, 2'b11, 32'd3,        32'hFFFFFFFE, 32'd10,      32'h00000004};
    vecs[4]  = '{MUL_LO,  2'b00, 32'd7,        32'd6,        32'd0,       32'd42};
    vecs[5]  = '{MUL_LO,  2'b11, 32'hFFFFFFFD, 32'd5,        32'd0,       32'hFFFFFFF1};
    vecs[6]  = '{MUL_HI,  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,       32'h00000000};
    vecs[7]  = '{MUL_HI,  2'b00, 32'h12345678, 32'h00000010, 32'd0,       32'h00000001};
    vecs[8]  = '{MUL_LO,  2'b00, 32'h00010000, 32'h00010000, 32'd0,       32'h00000000};
    vecs[9]  = '{MUL_MAC, 2'b00, 32'd1,        32'd1,        32'hFFFFFFFF, 32'h00000000};
    vecs[10] = '{MUL_HI,  2'b10, 32'd2,        32'h80000000, 32'd0,       32'hFFFFFFFF};
    vecs[11] = '{MUL_HI,  2'b11, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0,       32'h3FFFFFFF};
    vecs[12] = '{MUL_LO,  2'b00, 32'd5,        32'd0,        32'd0,       32'd0};
    vecs[13] = '{MUL_LO,  2'b00, 32'd2,        32'h0000FFFF, 32'd0,       32'h0001FFFE};

    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b0;
    operator_i = 2'b00; signed_i = 2'b00;
    op_a_i = 32'd0; op_b_i = 32'd0; op_c_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {29'd0, ready_o, valid_o, multicycle_o, result_o}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    rst_n = 1'b1;

    // Flush blocks acceptance in IDLE.
    drive(vecs[4]);
    flush_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_idle", {62'd0, ready_o, multicycle_o}, 64'd2);

    for (int i = 0; i < 14; i++) do_op(vecs[i], 0, $sformatf("v%0d", i));

    // Flush after two CALC cycles: back to IDLE, no result.
    v = '{MUL_LO, 2'b00, 32'd1, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF};
    drive(v);
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_calc", {61'd0, ready_o, valid_o, multicycle_o}, 64'd4);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (valid_o) seen++;
    end
    chk("flush_novalid", 64'(seen), 64'd0);
    do_op(vecs[4], 0, "after_flush");

    // Consumer stalls three cycles in DONE.
    do_op(vecs[0], 3, "stall");

    // Flush beats ex_ready in DONE.
    v = '{MUL_LO, 2'b00, 32'd3, 32'd4, 32'd0, 32'd12};
    drive(v);
    @(posedge clk); #1;
    valid_i = 1'b0;
    sb_q.push_back(v.exp);
    cnt = 0;
    while (!valid_o && cnt < 50) begin @(posedge clk); #1; cnt++; end
    chk("fdone_res", {31'd0, valid_o, result_o}, {31'd0, 1'b1, sb_q.pop_front()});
    flush_i = 1'b1; ex_ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; ex_ready_i = 1'b0;
    chk("fdone_idle", {30'd0, ready_o, valid_o, result_o}, {30'd0, 1'b1, 1'b0, 32'd0});

    // Reset in the middle of CALC.
    drive(vecs[11]);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_calc", {29'd0, ready_o, valid_o, multicycle_o, result_o}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    do_op(vecs[3], 0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
